i2c_txn_sequencer: RTL and testbench



---
 rtl/i2c_txn_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// Register-level I2C transaction sequencer: turns one write/read command
// into a stream of bit/byte engine primitives, with device-address retry.
module i2c_txn_sequencer #(
   parameter int REG_ADDR_BYTES = 1,
   parameter int MAX_LEN        = 4,
   parameter int LEN_W          = 3,
   parameter int RETRIES        = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_rw,
   input  logic [6:0]                  cmd_dev_addr,
   input  logic [8*REG_ADDR_BYTES-1:0] cmd_reg_addr,
   input  logic [LEN_W-1:0]            cmd_len,
   input  logic [8*MAX_LEN-1:0]        wr_data,
   input  logic                        req_next,
   input  logic                        ack_failed,
   input  logic [7:0]                  rx_byte,
   output logic [2:0]                  send_next_state,
   output logic [7:0]                  send_byte_data,
   output logic [8*MAX_LEN-1:0]        rd_data,
   output logic                        done,
   output logic                        error
);

   localparam logic [2:0] P_GET   = 3'd0;
   localparam logic [2:0] P_START = 3'd1;
   localparam logic [2:0] P_ONE   = 3'd2;
   localparam logic [2:0] P_RSTRT = 3'd3;
   localparam logic [2:0] P_STOP  = 3'd4;
   localparam logic [2:0] P_BYTE  = 3'd5;
   localparam logic [2:0] P_RECV  = 3'd6;
   localparam logic [2:0] P_ZERO  = 3'd7;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [1:0] REG_LAST = 2'(REG_ADDR_BYTES - 1);
   localparam logic [1:0] RETRY_MAX = 2'(RETRIES);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_DEV_W, S_REG, S_WDATA, S_RSTART,
      S_DEV_R, S_RDATA, S_ACK, S_NACK, S_STOP
   } state_t;

   state_t                      state;
   logic                        rw_q;
   logic [6:0]                  dev_q;
   logic [8*REG_ADDR_BYTES-1:0] reg_q;
   logic [8*MAX_LEN-1:0]        wdata_q;
   logic [LEN_W-1:0]            len_q;
   logic [LEN_W-1:0]            byte_cnt;
   logic [1:0]                  reg_cnt;
   logic [1:0]                  retry_cnt;
   logic                        retry_pend;
   logic [LEN_W-1:0]            len_clamp;

   assign cmd_ready = (state == S_IDLE);

   always_comb begin
      len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
      if (cmd_rw && len_clamp == '0)
         len_clamp = LEN_W'(1);
   end

   always_comb begin
      send_next_state = P_GET;
      send_byte_data  = 8'h00;
      case (state)
         S_START:  send_next_state = P_START;
         S_DEV_W: begin
            send_next_state = P_BYTE;
            send_byte_data  = {dev_q, 1'b0};
         end
         S_REG: begin
            send_next_state = P_BYTE;
            send_byte_data  = reg_q[8*REG_ADDR_BYTES-1 -: 8];
         end
         S_WDATA: begin
            send_next_state = P_BYTE;
            send_byte_data  = wdata_q[7:0];
         end
         S_RSTART: send_next_state = P_RSTRT;
         S_DEV_R: begin
            send_next_state = P_BYTE;
            send_byte_data  = {dev_q, 1'b1};
         end
         S_RDATA:  send_next_state = P_RECV;
         S_ACK:    send_next_state = P_ZERO;
         S_NACK:   send_next_state = P_ONE;
         S_STOP:   send_next_state = P_STOP;
         default:  send_next_state = P_GET;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         rw_q       <= 1'b0;
         dev_q      <= '0;
         reg_q      <= '0;
         wdata_q    <= '0;
         len_q      <= '0;
         byte_cnt   <= '0;
         reg_cnt    <= '0;
         retry_cnt  <= '0;
         retry_pend <= 1'b0;
         rd_data    <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (cmd_valid) begin
               rw_q       <= cmd_rw;
               dev_q      <= cmd_dev_addr;
               reg_q      <= cmd_reg_addr;
               wdata_q    <= wr_data;
               len_q      <= len_clamp;
               byte_cnt   <= '0;
               reg_cnt    <= '0;
               retry_cnt  <= '0;
               retry_pend <= 1'b0;
               rd_data    <= '0;
               error      <= 1'b0;
               state      <= S_START;
            end
         end else if (req_next) begin
            // a NACK on any byte we sent overrides the normal advance
            if (send_next_state == P_BYTE && ack_failed) begin
               state <= S_STOP;
               if (state == S_DEV_W && retry_cnt < RETRY_MAX) begin
                  retry_cnt  <= retry_cnt + 2'd1;
                  retry_pend <= 1'b1;
               end else begin
                  error <= 1'b1;
               end
            end else begin
               case (state)
                  S_START: begin
                     reg_cnt  <= '0;
                     byte_cnt <= '0;
                     state    <= S_DEV_W;
                  end
                  S_DEV_W: state <= S_REG;
                  S_REG: begin
                     reg_q   <= reg_q << 8;
                     reg_cnt <= reg_cnt + 2'd1;
                     if (reg_cnt == REG_LAST) begin
                        if (rw_q)
                           state <= S_RSTART;
                        else if (len_q == '0)
                           state <= S_STOP;
                        else
                           state <= S_WDATA;
                     end
                  end
                  S_WDATA: begin
                     wdata_q <= wdata_q >> 8;
                     if (byte_cnt == len_q - 1'b1) begin
                        state <= S_STOP;
                     end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                     end
                  end
                  S_RSTART: state <= S_DEV_R;
                  S_DEV_R:  state <= S_RDATA;
                  S_RDATA: begin
                     for (int i = 0; i < MAX_LEN; i++)
                        if (byte_cnt == LEN_W'(i))
                           rd_data[8*i +: 8] <= rx_byte;
                     if (byte_cnt == len_q - 1'b1)
                        state <= S_NACK;
                     else
                        state <= S_ACK;
                  end
                  S_ACK: begin
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= S_RDATA;
                  end
                  S_NACK: state <= S_STOP;
                  S_STOP: begin
                     if (retry_pend) begin
                        retry_pend <= 1'b0;
                        state      <= S_START;
                     end else begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Scoreboard bench: scripted engine model checks every primitive,
// a done monitor checks error/rd_data per command.
module tb_i2c_txn_sequencer;

   localparam logic [2:0] P_GET = 3'd0;
   localparam logic [2:0] P_ST  = 3'd1;
   localparam logic [2:0] P_ONE = 3'd2;
   localparam logic [2:0] P_RS  = 3'd3;
   localparam logic [2:0] P_SP  = 3'd4;
   localparam logic [2:0] P_SB  = 3'd5;
   localparam logic [2:0] P_RX  = 3'd6;
   localparam logic [2:0] P_ZR  = 3'd7;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   function automatic logic [10:0] pr(logic [2:0] c, logic [7:0] b);
      return {c, b};
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : eng
      localparam int RB = g + 1;
      logic            cmd_valid;
      logic            cmd_ready;
      logic            cmd_rw;
      logic [6:0]      dev;
      logic [8*RB-1:0] reg_a;
      logic [2:0]      len;
      logic [31:0]     wr;
      logic            req_next;
      logic            ack_failed;
      logic [7:0]      rx;
      logic [2:0]      sns;
      logic [7:0]      sbd;
      logic [31:0]     rd;
      logic            done;
      logic            error;
      logic [10:0]     exp_q[$];
      logic            nack_q[$];
      logic [7:0]      rx_q[$];
      logic [32:0]     done_q[$];

      i2c_txn_sequencer #(
         .REG_ADDR_BYTES(RB), .MAX_LEN(4), .LEN_W(3), .RETRIES(1)
      ) dut (
         .clock(clock), .reset(reset),
         .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
         .cmd_rw(cmd_rw), .cmd_dev_addr(dev),
         .cmd_reg_addr(reg_a), .cmd_len(len), .wr_data(wr),
         .req_next(req_next), .ack_failed(ack_failed), .rx_byte(rx),
         .send_next_state(sns), .send_byte_data(sbd),
         .rd_data(rd), .done(done), .error(error)
      );

      // engine model: answers a primitive only while one is expected
      initial begin
         logic [10:0] e;
         int pc;
         pc = 0;
         cmd_valid = 1'b0; cmd_rw = 1'b0; dev = '0; reg_a = '0;
         len = '0; wr = '0;
         req_next = 1'b0; ack_failed = 1'b0; rx = 8'h00;
         forever begin
            @(negedge clock);
            if (!reset && exp_q.size() > 0 && sns != P_GET) begin
               e = exp_q.pop_front();
               chk($sformatf("prim%0d_%0d", g, pc), 64'({sns, sbd}), 64'(e));
               pc++;
               ack_failed = 1'b0;
               rx = 8'h00;
               if (sns == P_SB && nack_q.size() > 0)
                  ack_failed = nack_q.pop_front();
               if (sns == P_RX && rx_q.size() > 0)
                  rx = rx_q.pop_front();
               req_next = 1'b1;
               @(negedge clock);
               req_next = 1'b0;
               ack_failed = 1'b0;
            end
         end
      end

      initial begin
         logic [32:0] d;
         forever begin
            @(negedge clock);
            if (done) begin
               if (done_q.size() == 0) begin
                  chk($sformatf("spurious_done%0d", g), 64'(1), 64'(0));
               end else begin
                  d = done_q.pop_front();
                  chk($sformatf("done%0d", g), 64'({error, rd}), 64'(d));
               end
            end
         end
      end
   end

   task automatic wait_idle(int k, string nm);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      while (n < 3000 && !ok) begin
         @(negedge clock);
         if (k == 0)
            ok = eng[0].exp_q.size() == 0 && eng[0].done_q.size() == 0;
         else
            ok = eng[1].exp_q.size() == 0 && eng[1].done_q.size() == 0;
         n++;
      end
      chk({nm, "_complete"}, 64'(ok), 64'(1));
   endtask

   task automatic go0(logic rw, logic [6:0] d, logic [7:0] r,
                      logic [2:0] l, logic [31:0] w);
      @(negedge clock);
      eng[0].cmd_rw = rw; eng[0].dev = d; eng[0].reg_a = r;
      eng[0].len = l; eng[0].wr = w; eng[0].cmd_valid = 1'b1;
      @(negedge clock);
      eng[0].cmd_valid = 1'b0;
   endtask

   task automatic go1(logic rw, logic [6:0] d, logic [15:0] r,
                      logic [2:0] l, logic [31:0] w);
      @(negedge clock);
      eng[1].cmd_rw = rw; eng[1].dev = d; eng[1].reg_a = r;
      eng[1].len = l; eng[1].wr = w; eng[1].cmd_valid = 1'b1;
      @(negedge clock);
      eng[1].cmd_valid = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_ready0", 64'(eng[0].cmd_ready), 64'(1));
      chk("rst_prim0", 64'({eng[0].sns, eng[0].sbd}), 64'(0));
      chk("rst_rd0", 64'(eng[0].rd), 64'(0));
      chk("rst_flags0", 64'({eng[0].done, eng[0].error}), 64'(0));
      chk("rst_ready1", 64'(eng[1].cmd_ready), 64'(1));
      chk("rst_prim1", 64'({eng[1].sns, eng[1].sbd}), 64'(0));

      // write 2 bytes
      eng[0].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h10),
                       pr(P_SB, 8'hAB), pr(P_SB, 8'hCD), pr(P_SP, 8'h00)};
      eng[0].done_q.push_back({1'b0, 32'h0});
      go0(1'b0, 7'h1D, 8'h10, 3'd2, 32'h0000_CDAB);
      wait_idle(0, "wr2");

      // read 3 bytes
      eng[0].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h32),
                       pr(P_RS, 8'h00), pr(P_SB, 8'h3B), pr(P_RX, 8'h00),
                       pr(P_ZR, 8'h00), pr(P_RX, 8'h00), pr(P_ZR, 8'h00),
                       pr(P_RX, 8'h00), pr(P_ONE, 8'h00), pr(P_SP, 8'h00)};
      eng[0].rx_q = '{8'h11, 8'h22, 8'h33};
      eng[0].done_q.push_back({1'b0, 32'h0033_2211});
      go0(1'b1, 7'h1D, 8'h32, 3'd3, 32'h0);
      wait_idle(0, "rd3");

      // device NACK on both attempts
      eng[0].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SP, 8'h00),
                       pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SP, 8'h00)};
      eng[0].nack_q = '{1'b1, 1'b1};
      eng[0].done_q.push_back({1'b1, 32'h0});
      go0(1'b0, 7'h1D, 8'h10, 3'd1, 32'h0000_00AB);
      wait_idle(0, "nack_all");

      // device NACK on first attempt only
      eng[0].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SP, 8'h00),
                       pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h10),
                       pr(P_SB, 8'hAB), pr(P_SP, 8'h00)};
      eng[0].nack_q = '{1'b1};
      eng[0].done_q.push_back({1'b0, 32'h0});
      go0(1'b0, 7'h1D, 8'h10, 3'd1, 32'h0000_00AB);
      wait_idle(0, "nack_once");

      // NACK on first data byte: no retry, second byte never sent
      eng[0].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h10),
                       pr(P_SB, 8'hAB), pr(P_SP, 8'h00)};
      eng[0].nack_q = '{1'b0, 1'b0, 1'b1};
      eng[0].done_q.push_back({1'b1, 32'h0});
      go0(1'b0, 7'h1D, 8'h10, 3'd2, 32'h0000_CDAB);
      wait_idle(0, "nack_data");

      // reset while waiting on read byte 1
      eng[0].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h32),
                       pr(P_RS, 8'h00), pr(P_SB, 8'h3B), pr(P_RX, 8'h00),
                       pr(P_ZR, 8'h00)};
      eng[0].rx_q = '{8'h11};
      go0(1'b1, 7'h1D, 8'h32, 3'd3, 32'h0);
      n = 0;
      while (n < 500 && !(eng[0].exp_q.size() == 0 && eng[0].sns == P_RX)) begin
         @(negedge clock);
         n++;
      end
      chk("mid_rdata", 64'(eng[0].sns), 64'(P_RX));
      chk("mid_rd", 64'(eng[0].rd), 64'h11);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_mid_prim", 64'(eng[0].sns), 64'(P_GET));
      chk("rst_mid_ready", 64'(eng[0].cmd_ready), 64'(1));
      chk("rst_mid_rd", 64'(eng[0].rd), 64'(0));
      chk("rst_mid_done", 64'(eng[0].done), 64'(0));

      // read with len 0 behaves as len 1
      eng[0].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h05),
                       pr(P_RS, 8'h00), pr(P_SB, 8'h3B), pr(P_RX, 8'h00),
                       pr(P_ONE, 8'h00), pr(P_SP, 8'h00)};
      eng[0].rx_q = '{8'h5A};
      eng[0].done_q.push_back({1'b0, 32'h0000_005A});
      go0(1'b1, 7'h1D, 8'h05, 3'd0, 32'h0);
      wait_idle(0, "rd_len0");
      chk("err_held", 64'(eng[0].error), 64'(0));

      // 2-byte register address, address-only write
      eng[1].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h12),
                       pr(P_SB, 8'h34), pr(P_SP, 8'h00)};
      eng[1].done_q.push_back({1'b0, 32'h0});
      go1(1'b0, 7'h1D, 16'h1234, 3'd0, 32'hFFFF_FFFF);
      wait_idle(1, "wr_len0");

      // len 7 clamps to 4
      eng[1].exp_q = '{pr(P_ST, 8'h00), pr(P_SB, 8'h3A), pr(P_SB, 8'h12),
                       pr(P_SB, 8'h34), pr(P_SB, 8'h11), pr(P_SB, 8'h22),
                       pr(P_SB, 8'h33), pr(P_SB, 8'h44), pr(P_SP, 8'h00)};
      eng[1].done_q.push_back({1'b0, 32'h0});
      go1(1'b0, 7'h1D, 16'h1234, 3'd7, 32'h4433_2211);
      wait_idle(1, "wr_clamp");

      repeat (5) @(negedge clock);
      chk("end_ready0", 64'(eng[0].cmd_ready), 64'(1));
      chk("end_ready1", 64'(eng[1].cmd_ready), 64'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
